// File: rtl/alu_mdu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : alu_mdu                                                          |
// | Brief    : Execute-stage ALU with iterative multiply/divide and HI/LO regs. |
// |            Define ALU_MDU_DIV_EN to build the restoring divider.            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             out_valid,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);

   localparam int c_cw = $clog2(WIDTH + 1);
   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_mul  = 2'd1;
   localparam logic [1:0] c_fix  = 2'd3;
`ifdef ALU_MDU_DIV_EN
   localparam logic [1:0] c_div  = 2'd2;
`endif
   localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   if (WIDTH < 4) begin : g_width_check
      $error("alu_mdu: WIDTH must be at least 4");
   end

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [c_cw-1:0]    r_cnt;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_m;
   logic               r_neg;
   logic               r_pend;
   logic [WIDTH-1:0]   r_pend_val;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_out_valid;

   logic               w_accept;
   logic               w_is_mul;
   logic               w_start;
   logic               w_signed;
   logic [WIDTH-1:0]   w_alu;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

`ifdef ALU_MDU_DIV_EN
   logic               w_is_div;
   logic               w_dbz;
   logic               w_ovf;
   logic [WIDTH:0]     w_div_sh;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_diff;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               r_is_div;
   logic               r_neg_rem;
   logic               r_dbz;
   logic               r_ovf;
   logic [WIDTH-1:0]   r_a;
`endif

   assign w_accept = in_valid && in_ready;
   assign w_is_mul = (op[3:1] == 3'b100);
   assign w_signed = ~op[0];
   assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (-a) : a;
   assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (-b) : b;
`ifdef ALU_MDU_DIV_EN
   assign w_is_div = (op[3:1] == 3'b101);
   assign w_start  = w_is_mul || w_is_div;
   assign w_dbz    = (b == '0);
   assign w_ovf    = w_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
`else
   assign w_start  = w_is_mul;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle: begin
            if (w_accept && w_is_mul) w_next = c_mul;
`ifdef ALU_MDU_DIV_EN
            if (w_accept && w_is_div) w_next = c_div;
`endif
         end
         c_mul:   if (r_cnt == c_last) w_next = c_fix;
`ifdef ALU_MDU_DIV_EN
         c_div:   if (r_cnt == c_last) w_next = c_fix;
`endif
         c_fix:   w_next = c_idle;
         default: w_next = c_idle;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready = (r_state == c_idle);
      busy     = (r_state != c_idle);
   end

   always_comb begin
      w_alu = '0;
      case (op)
         4'b0000: w_alu = a & b;
         4'b0001: w_alu = a | b;
         4'b0011: w_alu = a ^ b;
         4'b0100: w_alu = ~(a | b);
         4'b0010: w_alu = a + b;
         4'b0110: w_alu = a - b;
         4'b0111: w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0101: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
         4'b1100: w_alu = r_hi;
         4'b1101: w_alu = r_lo;
         default: w_alu = '0;
      endcase
   end

   // Shift-add step: multiplier sits in r_q and is shifted out as the product shifts in
   assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

`ifdef ALU_MDU_DIV_EN
   // Restoring step: remainder stays below the divisor, so the difference fits in WIDTH bits
   assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
   assign w_div_ge   = (w_div_sh >= {1'b0, r_m});
   assign w_div_diff = w_div_sh[WIDTH-1:0] - r_m;
`endif

   always_comb begin
      w_prod     = {r_acc, r_q};
      w_prod_fix = r_neg ? (-w_prod) : w_prod;
      w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo   = w_prod_fix[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
      w_quo = r_neg ? (-r_q) : r_q;
      w_rem = r_neg_rem ? (-r_acc) : r_acc;
      if (r_is_div) begin
         if (r_dbz) begin
            w_fix_hi = r_a;
            w_fix_lo = '1;
         end else if (r_ovf) begin
            w_fix_hi = '0;
            w_fix_lo = r_a;
         end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_acc       <= '0;
         r_q         <= '0;
         r_m         <= '0;
         r_neg       <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_val  <= '0;
         r_result    <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_out_valid <= 1'b0;
`ifdef ALU_MDU_DIV_EN
         r_is_div    <= 1'b0;
         r_neg_rem   <= 1'b0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
         r_a         <= '0;
`endif
      end else begin
         // Single-cycle results are staged one edge so they appear one clock after acceptance
         r_out_valid <= r_pend;
         r_pend      <= 1'b0;
         if (r_pend) r_result <= r_pend_val;
         case (r_state)
            c_idle: begin
               if (w_accept) begin
                  if (w_start) begin
                     r_cnt <= '0;
                     r_acc <= '0;
                     r_q   <= w_abs_a;
                     r_m   <= w_abs_b;
                     r_neg <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
                     r_is_div  <= w_is_div;
                     r_neg_rem <= w_signed && a[WIDTH-1];
                     r_dbz     <= w_dbz;
                     r_ovf     <= w_ovf;
                     r_a       <= a;
`endif
                  end else begin
                     r_pend     <= 1'b1;
                     r_pend_val <= w_alu;
                  end
               end
            end
            c_mul: begin
               r_acc <= w_mul_sum[WIDTH:1];
               r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
               r_cnt <= r_cnt + c_one;
            end
`ifdef ALU_MDU_DIV_EN
            c_div: begin
               r_acc <= w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
               r_q   <= {r_q[WIDTH-2:0], w_div_ge};
               r_cnt <= r_cnt + c_one;
            end
`endif
            c_fix: begin
               r_hi        <= w_fix_hi;
               r_lo        <= w_fix_lo;
               r_result    <= w_fix_lo;
               r_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result    = r_result;
   assign zero      = (r_result == '0);
   assign out_valid = r_out_valid;
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_alu_mdu                                                       |
// | Brief    : Directed self-checking bench for alu_mdu (WIDTH = 32).           |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_alu_mdu;
   localparam int W = 32;
   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_XOR = 4'b0011, OP_NOR = 4'b0100;
   localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_MFHI = 4'b1100, OP_MFLO = 4'b1101, OP_BAD = 4'b1110;
   localparam logic [3:0] OP_MULT = 4'b1000, OP_MULTU = 4'b1001, OP_DIV = 4'b1010, OP_DIVU = 4'b1011;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [3:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready, zero, out_valid, busy;
   logic [W-1:0]  result, hi, lo;
   int            n_tests = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .result    (result),
      .zero      (zero),
      .out_valid (out_valid),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      in_valid = 1'b1;
      op       = o;
      a        = x;
      b        = y;
   endtask

   task automatic run1(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp);
      @(negedge clk); drive(o, x, y);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_ov"}, out_valid, 1);
      check(tag, result, exp);
   endtask

   task automatic run_multi(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                            input logic [W-1:0] exp_lo);
      int k  = 0;
      int nb = 0;
      @(negedge clk); drive(o, x, y);
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         k++;
         if (busy) nb++;
      end while (!out_valid && k < 100);
      check({tag, "_done"}, out_valid, 1);
      check({tag, "_lat"}, k - 1, W + 1);
      check({tag, "_busy"}, nb, W + 1);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      check({tag, "_res"}, result, exp_lo);
      check({tag, "_rdy"}, in_ready, 1);
   endtask

   initial begin
      int pulses;
      int k;

      repeat (3) @(negedge clk);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_ov", out_valid, 0);
      rst_n = 1'b1;

      // ADD wraps to zero; result appears one edge after acceptance
      @(negedge clk); drive(OP_ADD, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk); in_valid = 1'b0;
      check("add_ov_n", out_valid, 0);
      @(negedge clk);
      check("add_ov_n1", out_valid, 1);
      check("add_res", result, 0);
      check("add_zero", zero, 1);

      // Back-to-back SLT, SLTU, SUB
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) check("b2b_ov", out_valid, 1);
         if (i == 2) check("slt", result, 32'h1);
         if (i == 3) check("sltu", result, 32'h0);
         if (i == 4) begin
            check("sub", result, 32'hFFFF_FFFE);
            check("sub_zero", zero, 0);
         end
         if (i == 0) drive(OP_SLT, 32'hFFFF_FFFF, 32'h1);
         else if (i == 1) drive(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
         else if (i == 2) drive(OP_SUB, 32'h5, 32'h7);
         else in_valid = 1'b0;
      end

      run1("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
      run1("or", OP_OR, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
      run1("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
      run1("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF);
      run1("slt_pos", OP_SLT, 32'h5, 32'hFFFF_FFFF, 32'h0);
      run1("sltu_pos", OP_SLTU, 32'h5, 32'hFFFF_FFFF, 32'h1);
      run1("bad_op", OP_BAD, 32'h1, 32'h1, 32'h0);

      run_multi("mult", OP_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run1("mfhi", OP_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF);
      run_multi("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run1("mflo", OP_MFLO, 32'h0, 32'h0, 32'h0000_0001);

`ifdef ALU_MDU_DIV_EN
      run_multi("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_multi("divu_dbz", OP_DIVU, 32'h9, 32'h0, 32'h9, 32'hFFFF_FFFF);
      run_multi("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_multi("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
`endif

      // Reset mid-MULTU after ten iterations
      @(negedge clk); drive(OP_MULTU, 32'h5, 32'h6);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      check("abort_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_ov", out_valid, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      check("abort_result", result, 0);
      check("abort_ready", in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("abort_no_ov", pulses, 0);

      // ADD held valid while busy is accepted only once in_ready returns
      @(negedge clk); drive(OP_MULT, 32'h2, 32'h3);
      @(negedge clk); drive(OP_ADD, 32'd10, 32'd20);
      k = 1;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("hold_mul_lat", k - 1, W + 1);
      check("hold_mul_res", result, 32'd6);
      @(negedge clk); in_valid = 1'b0;
      check("hold_gap_ov", out_valid, 0);
      check("hold_gap_res", result, 32'd6);
      @(negedge clk);
      check("hold_add_ov", out_valid, 1);
      check("hold_add_res", result, 32'd30);

`ifndef ALU_MDU_DIV_EN
      @(negedge clk); drive(OP_DIVU, 32'd8, 32'd2);
      @(negedge clk); in_valid = 1'b0;
      check("nodiv_busy", busy, 0);
      check("nodiv_ready", in_ready, 1);
      @(negedge clk);
      check("nodiv_ov", out_valid, 1);
      check("nodiv_res", result, 0);
      check("nodiv_busy2", busy, 0);
      check("nodiv_hi", hi, 0);
      check("nodiv_lo", lo, 32'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
